// File: rtl/lt24_bus_pkg.sv
// lt24_bus_pkg: shared constants, FSM state type and the bus-word table for
// the LT24 (ILI9341, 8080-style) pixel sink.
//   word_at() maps a word index 0..11 of a full pixel transfer onto the
//   {RS, data} pair that goes on the bus. Index 11 is the pixel itself, so a
//   streaming transfer is simply a transfer that starts at the last index.
package lt24_bus_pkg;

    localparam logic [7:0] CMD_COL_SET   = 8'h2A;
    localparam logic [7:0] CMD_PAGE_SET  = 8'h2B;
    localparam logic [7:0] CMD_MEM_WRITE = 8'h2C;

    localparam int LCD_WIDTH_DEF  = 240;
    localparam int LCD_HEIGHT_DEF = 320;

    localparam int                WIDX_W    = 4;
    localparam logic [WIDX_W-1:0] WIDX_LAST = 4'd11;

    typedef enum logic [1:0] {IDLE, SETUP, STROBE_LO, STROBE_HI} state_t;

    typedef struct packed {
        logic        rs;    // 0 = command, 1 = data
        logic [15:0] data;
    } bus_word_t;

    // w_end is the low byte of the column window end; the high byte is
    // always zero for the 8-bit column range, so it goes out as 0x00.
    function automatic bus_word_t word_at(input logic [WIDX_W-1:0] idx,
                                          input logic [7:0]        x,
                                          input logic [8:0]        y,
                                          input logic [15:0]       pix,
                                          input logic [7:0]        w_end,
                                          input logic [15:0]       h_end);
        bus_word_t w;
        w.rs   = 1'b1;
        w.data = 16'h0000;
        case (idx)
            4'd0:  begin w.rs = 1'b0; w.data = {8'h00, CMD_COL_SET};   end
            4'd1:  w.data = 16'h0000;               // x[15:8], zero-extended
            4'd2:  w.data = {8'h00, x};
            4'd3:  w.data = 16'h0000;               // column end [15:8]
            4'd4:  w.data = {8'h00, w_end};
            4'd5:  begin w.rs = 1'b0; w.data = {8'h00, CMD_PAGE_SET};  end
            4'd6:  w.data = {15'h0000, y[8]};
            4'd7:  w.data = {8'h00, y[7:0]};
            4'd8:  w.data = {8'h00, h_end[15:8]};
            4'd9:  w.data = {8'h00, h_end[7:0]};
            4'd10: begin w.rs = 1'b0; w.data = {8'h00, CMD_MEM_WRITE}; end
            default: w.data = pix;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/lt24_pixel_sink_if.sv
// lt24_pixel_sink_if: pixel producer -> sink handshake.
//   xAddr/yAddr/pixelData qualified by pixelWrite; a pixel is taken on a
//   clock edge where pixelWrite && pixelReady.
//   master = producer (renderer), slave = lt24_pixel_sink.
interface lt24_pixel_sink_if;
    logic [7:0]  xAddr;
    logic [8:0]  yAddr;
    logic [15:0] pixelData;
    logic        pixelWrite;
    logic        pixelReady;

    modport master (output xAddr, yAddr, pixelData, pixelWrite, input pixelReady);
    modport slave  (input  xAddr, yAddr, pixelData, pixelWrite, output pixelReady);
endinterface

// File: rtl/lt24_word_strobe.sv
// lt24_word_strobe: puts one bus word on the LT24 pins with 8080 write timing.
//   clock, reset_n : clock, synchronous active-low reset
//   start          : load word and begin SETUP (from IDLE, or chained from the
//                    done cycle of the previous word)
//   word           : {rs, data} to drive
//   wr_n, rs, data : registered bus pins
//   done           : high in the last STROBE_HI cycle of the current word
// Sequence per word: SETUP (1) -> STROBE_LO (WR_LOW_CYCLES) -> STROBE_HI
// (WR_HIGH_CYCLES). rs/data change only when a word is loaded, so they are
// stable from SETUP through the end of STROBE_HI.
module lt24_word_strobe
    import lt24_bus_pkg::*;
#(
    parameter int WR_LOW_CYCLES  = 1,
    parameter int WR_HIGH_CYCLES = 1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  bus_word_t   word,
    output logic        wr_n,
    output logic        rs,
    output logic [15:0] data,
    output logic        done
);

    localparam int MAXC = (WR_LOW_CYCLES > WR_HIGH_CYCLES) ? WR_LOW_CYCLES : WR_HIGH_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
            wr_n  <= 1'b1;
            rs    <= 1'b1;
            data  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            // registered from next state so the pin is glitch-free
            wr_n  <= (state_nxt != STROBE_LO);
            if (start) begin
                rs   <= word.rs;
                data <= word.data;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = SETUP;
            end
            SETUP: begin
                state_nxt = STROBE_LO;
                cnt_nxt   = CW'(WR_LOW_CYCLES - 1);
            end
            STROBE_LO: begin
                if (cnt == '0) begin
                    state_nxt = STROBE_HI;
                    cnt_nxt   = CW'(WR_HIGH_CYCLES - 1);
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            STROBE_HI: begin
                if (cnt == '0) begin
                    done      = 1'b1;
                    state_nxt = start ? SETUP : IDLE;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: rtl/lt24_pixel_sink.sv
// lt24_pixel_sink: accepts pixels on a ready/write handshake and writes each
// one to an ILI9341 on the LT24 parallel bus.
//   clock, reset_n : clock, synchronous active-low reset
//   pix            : lt24_pixel_sink_if.slave (xAddr, yAddr, pixelData,
//                    pixelWrite in; pixelReady out)
//   LT24Wr_n/Rd_n/CS_n/RS/Data : LCD bus pins (Rd_n tied high)
// A full transfer is 12 words: column set, page set, memory write + pixel.
// Out-of-range pixels are dropped without touching the bus.
// Optional macro LT24_STREAM_SKIP_ADDR_EN: remember the address the
// controller will auto-increment to after each pixel; a pixel that lands
// there is sent as the single data word. Without the macro every in-range
// pixel takes the full transfer.
module lt24_pixel_sink
    import lt24_bus_pkg::*;
#(
    parameter int LCD_WIDTH      = LCD_WIDTH_DEF,
    parameter int LCD_HEIGHT     = LCD_HEIGHT_DEF,
    parameter int WR_LOW_CYCLES  = 1,
    parameter int WR_HIGH_CYCLES = 1
) (
    input  logic               clock,
    input  logic               reset_n,
    lt24_pixel_sink_if.slave   pix,
    output logic               LT24Wr_n,
    output logic               LT24Rd_n,
    output logic               LT24CS_n,
    output logic               LT24RS,
    output logic [15:0]        LT24Data
);

    localparam logic [15:0] W_END = 16'(LCD_WIDTH - 1);
    localparam logic [15:0] H_END = 16'(LCD_HEIGHT - 1);

    logic [7:0]        x_q;
    logic [8:0]        y_q;
    logic [15:0]       pix_q;
    logic [WIDX_W-1:0] idx, idx_inc, first_idx;
    logic              busy, busy_nxt, ready_q;
    logic              accept, in_range, go, stream, last, done, start;
    bus_word_t         first_w, next_w, word_sel;

    assign LT24Rd_n       = 1'b1;
    assign pix.pixelReady = ready_q;

    assign accept   = pix.pixelWrite && ready_q;
    assign in_range = ({24'd0, pix.xAddr} < 32'(LCD_WIDTH)) &&
                      ({23'd0, pix.yAddr} < 32'(LCD_HEIGHT));
    assign go       = accept && in_range;
    assign last     = (idx == WIDX_LAST);
    assign idx_inc  = idx + 1'b1;
    // next word is chained in the done cycle so there is no idle gap
    assign start    = go || (done && !last);
    assign busy_nxt = busy ? !(done && last) : go;

    // a streaming pixel starts straight at the pixel-data word
    assign first_idx = stream ? WIDX_LAST : '0;
    assign first_w   = word_at(first_idx, pix.xAddr, pix.yAddr, pix.pixelData, W_END[7:0], H_END);
    assign next_w    = word_at(idx_inc, x_q, y_q, pix_q, W_END[7:0], H_END);
    assign word_sel  = go ? first_w : next_w;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            busy     <= 1'b0;
            ready_q  <= 1'b0;
            idx      <= '0;
            x_q      <= '0;
            y_q      <= '0;
            pix_q    <= '0;
            LT24CS_n <= 1'b1;
        end else begin
            busy    <= busy_nxt;
            // registered so ready is low through reset and drops the cycle
            // after an accept
            ready_q <= !busy_nxt;
            if (go) begin
                x_q      <= pix.xAddr;
                y_q      <= pix.yAddr;
                pix_q    <= pix.pixelData;
                idx      <= first_idx;
                LT24CS_n <= 1'b0;
            end else if (done) begin
                if (last) LT24CS_n <= 1'b1;
                else      idx      <= idx_inc;
            end
        end
    end

`ifdef LT24_STREAM_SKIP_ADDR_EN
    logic       next_valid;
    logic [7:0] next_x;
    logic [8:0] next_y;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            next_valid <= 1'b0;
            next_x     <= '0;
            next_y     <= '0;
        end else if (accept && !in_range) begin
            next_valid <= 1'b0;
        end else if (done && last) begin
            next_valid <= 1'b1;
            // mirror the controller's auto-increment inside the full window
            if (x_q == W_END[7:0]) begin
                next_x <= '0;
                next_y <= (y_q == H_END[8:0]) ? '0 : y_q + 1'b1;
            end else begin
                next_x <= x_q + 1'b1;
                next_y <= y_q;
            end
        end
    end

    assign stream = next_valid && (pix.xAddr == next_x) && (pix.yAddr == next_y);
`else
    assign stream = 1'b0;
`endif

    lt24_word_strobe #(
        .WR_LOW_CYCLES (WR_LOW_CYCLES),
        .WR_HIGH_CYCLES(WR_HIGH_CYCLES)
    ) u_strobe (
        .clock  (clock),
        .reset_n(reset_n),
        .start  (start),
        .word   (word_sel),
        .wr_n   (LT24Wr_n),
        .rs     (LT24RS),
        .data   (LT24Data),
        .done   (done)
    );

endmodule

// File: tb/tb_lt24_pixel_sink.sv
// tb_lt24_pixel_sink: scoreboard bench for lt24_pixel_sink. Expected bus
// words are queued when a pixel is driven and popped when the monitor sees a
// Wr_n rising edge. A second instance with 3/2 strobe timing checks pulse
// widths. Honours LT24_STREAM_SKIP_ADDR_EN for streaming expectations.
module tb_lt24_pixel_sink;

    localparam int K_FULL = 0;
    localparam int K_STRM = 1;
    localparam int K_DROP = 2;
`ifdef LT24_STREAM_SKIP_ADDR_EN
    localparam int K_S = K_STRM;
`else
    localparam int K_S = K_FULL;
`endif

    logic        clock = 1'b0;
    logic        reset_n;
    logic        wr, rd, cs, rs;
    logic [15:0] data;
    logic        s_wr, s_rd, s_cs, s_rs;
    logic [15:0] s_data;

    lt24_pixel_sink_if pix();
    lt24_pixel_sink_if ps();

    lt24_pixel_sink dut (
        .clock(clock), .reset_n(reset_n), .pix(pix),
        .LT24Wr_n(wr), .LT24Rd_n(rd), .LT24CS_n(cs), .LT24RS(rs), .LT24Data(data)
    );

    lt24_pixel_sink #(.WR_LOW_CYCLES(3), .WR_HIGH_CYCLES(2)) dut_s (
        .clock(clock), .reset_n(reset_n), .pix(ps),
        .LT24Wr_n(s_wr), .LT24Rd_n(s_rd), .LT24CS_n(s_cs), .LT24RS(s_rs), .LT24Data(s_data)
    );

    always #5 clock = ~clock;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_words = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_s[$];
    logic        wr_prev = 1'b1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    function automatic void push(input logic r, input logic [15:0] d);
        exp_q.push_back({15'd0, r, d});
    endfunction

    function automatic void push_full(input logic [7:0] x, input logic [8:0] y, input logic [15:0] p);
        push(1'b0, 16'h002A); push(1'b1, 16'h0000); push(1'b1, {8'h00, x});
        push(1'b1, 16'h0000); push(1'b1, 16'h00EF);
        push(1'b0, 16'h002B); push(1'b1, {15'd0, y[8]}); push(1'b1, {8'h00, y[7:0]});
        push(1'b1, 16'h0001); push(1'b1, 16'h003F);
        push(1'b0, 16'h002C); push(1'b1, p);
    endfunction

    // bus monitor: the LCD latches on Wr_n rising; edges caused by reset are ignored
    always @(negedge clock) begin
        logic [31:0] e;
        if (reset_n && !wr_prev && wr) begin
            n_words++;
            chk("cs_at_latch", 32'(cs), 32'd0);
            if (exp_q.size() == 0) begin
                chk("unexpected_word", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                chk("bus_word", {15'd0, rs, data}, e);
            end
        end
        wr_prev = wr;
    end

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            if (pix.pixelReady) begin ok = 1'b1; break; end
        end
        if (!ok) chk("ready_wait", 32'(pix.pixelReady), 32'd1);
    endtask

    task automatic send(input logic [7:0] x, input logic [8:0] y, input logic [15:0] p, input int kind);
        bit ok;
        int n;
        wait_ready(ok);
        if (!ok) return;
        pix.xAddr = x; pix.yAddr = y; pix.pixelData = p; pix.pixelWrite = 1'b1;
        if (kind == K_FULL) push_full(x, y, p);
        else if (kind == K_STRM) push(1'b1, p);
        @(negedge clock);
        pix.pixelWrite = 1'b0;
        if (kind == K_DROP) begin
            for (int i = 0; i < 3; i++) begin
                chk("drop_ready", 32'(pix.pixelReady), 32'd1);
                chk("drop_cs", 32'(cs), 32'd1);
                chk("drop_wr", 32'(wr), 32'd1);
                @(negedge clock);
            end
            return;
        end
        chk("ready_drop", 32'(pix.pixelReady), 32'd0);
        chk("setup_cs", 32'(cs), 32'd0);
        chk("setup_wr", 32'(wr), 32'd1);
        @(negedge clock);
        chk("wr_fall", 32'(wr), 32'd0);
        n = 2;
        while (!pix.pixelReady && n < 100) begin
            @(negedge clock);
            n++;
        end
        chk("ready_lat", 32'(n), (kind == K_STRM) ? 32'd4 : 32'd37);
        chk("words_left", 32'(exp_q.size()), 32'd0);
    endtask

    typedef struct {
        logic [7:0]  x;
        logic [8:0]  y;
        logic [15:0] p;
        int          kind;
    } vec_t;
    vec_t vecs[$];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        pix.xAddr = '0; pix.yAddr = '0; pix.pixelData = '0; pix.pixelWrite = 1'b0;
        ps.xAddr  = '0; ps.yAddr  = '0; ps.pixelData  = '0; ps.pixelWrite  = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_ready", 32'(pix.pixelReady), 32'd0);
        chk("rst_wr",    32'(wr),   32'd1);
        chk("rst_rd",    32'(rd),   32'd1);
        chk("rst_cs",    32'(cs),   32'd1);
        chk("rst_rs",    32'(rs),   32'd1);
        chk("rst_data",  32'(data), 32'd0);
        chk("rst_s_rd",  32'(s_rd), 32'd1);
        chk("rst_s_cs",  32'(s_cs), 32'd1);
        reset_n = 1'b1;
        @(negedge clock);
        chk("ready_after_rst", 32'(pix.pixelReady), 32'd1);

        vecs.push_back('{8'd5,   9'd10,  16'hF800, K_FULL});
        vecs.push_back('{8'd6,   9'd10,  16'hF800, K_S});
        vecs.push_back('{8'd239, 9'd10,  16'h1234, K_FULL});
        vecs.push_back('{8'd0,   9'd11,  16'hABCD, K_S});
        vecs.push_back('{8'd239, 9'd319, 16'h5555, K_FULL});
        vecs.push_back('{8'd0,   9'd0,   16'h0001, K_S});
        vecs.push_back('{8'd2,   9'd0,   16'h0002, K_FULL});
        vecs.push_back('{8'd10,  9'd20,  16'h0F0F, K_FULL});
        vecs.push_back('{8'd240, 9'd0,   16'hFFFF, K_DROP});
        vecs.push_back('{8'd11,  9'd20,  16'h2222, K_FULL});
        vecs.push_back('{8'd0,   9'd320, 16'h3333, K_DROP});
        vecs.push_back('{8'd12,  9'd20,  16'h4444, K_FULL});
        foreach (vecs[i]) send(vecs[i].x, vecs[i].y, vecs[i].p, vecs[i].kind);

        // reset while the 7th word of a full transfer is strobing
        begin : rst_mid
            bit ok;
            int base;
            wait_ready(ok);
            pix.xAddr = 8'd100; pix.yAddr = 9'd100; pix.pixelData = 16'h7777; pix.pixelWrite = 1'b1;
            push_full(8'd100, 9'd100, 16'h7777);
            base = n_words;
            @(negedge clock);
            pix.pixelWrite = 1'b0;
            for (int i = 0; i < 100 && (n_words - base) < 6; i++) @(negedge clock);
            for (int i = 0; i < 10 && wr; i++) @(negedge clock);
            chk("rst_mid_words", 32'(n_words - base), 32'd6);
            chk("rst_mid_wr_low", 32'(wr), 32'd0);
            reset_n = 1'b0;
            @(negedge clock);
            chk("rst_mid_wr", 32'(wr), 32'd1);
            chk("rst_mid_cs", 32'(cs), 32'd1);
            chk("rst_mid_ready", 32'(pix.pixelReady), 32'd0);
            @(negedge clock);
            reset_n = 1'b1;
            exp_q.delete();
        end
        // (13,20) would have streamed after (12,20) without the reset
        send(8'd13, 9'd20, 16'h5A5A, K_FULL);

        // 3-low / 2-high strobe timing on the second instance
        begin : slow
            logic [31:0] e, fd, cur;
            int          lo, gap, nw, n;
            bit          pw, w, ok;
            push_full(8'd5, 9'd10, 16'hF800);
            exp_s = exp_q;
            exp_q.delete();
            ok = 1'b0;
            for (int i = 0; i < 50 && !ok; i++) begin
                @(negedge clock);
                ok = ps.pixelReady;
            end
            chk("slow_ready_wait", 32'(ps.pixelReady), 32'd1);
            ps.xAddr = 8'd5; ps.yAddr = 9'd10; ps.pixelData = 16'hF800; ps.pixelWrite = 1'b1;
            @(negedge clock);
            ps.pixelWrite = 1'b0;
            n = 1; pw = s_wr; lo = 0; gap = 0; nw = 0; fd = '0;
            while (!ps.pixelReady && n < 200) begin
                @(negedge clock);
                n++;
                w   = s_wr;
                cur = {15'd0, s_rs, s_data};
                if (pw && !w) begin
                    if (nw > 0) chk("slow_gap", 32'(gap), 32'd3);
                    lo = 1;
                    fd = cur;
                end else if (!pw && !w) begin
                    lo++;
                end else if (!pw && w) begin
                    chk("slow_lo_w", 32'(lo), 32'd3);
                    chk("slow_stable", cur, fd);
                    e = (exp_s.size() > 0) ? exp_s.pop_front() : 32'hFFFF_FFFF;
                    chk("slow_word", cur, e);
                    nw++;
                    gap = 1;
                end else begin
                    gap++;
                end
                pw = w;
            end
            chk("slow_words", 32'(nw), 32'd12);
            chk("slow_ready_lat", 32'(n), 32'd73);
        end

        repeat (4) @(negedge clock);
        chk("sb_end", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
